// File: rtl/cordic_mult_lin_param.sv
// Sequential linear-mode CORDIC multiplier: y ~= x * z_int, one shift-add step per clock,
// with valid/ready handshakes and an optional lower-part-OR approximate accumulator adder.
module cordic_mult_lin_param #(
  parameter int unsigned W           = 8,
  parameter int unsigned ITER        = 8,
  parameter int unsigned APPROX_LSBS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   z,
  input  logic           approx_en,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W:0]   y
);

  localparam int unsigned ACC_W = 2 * W + 1;
  localparam int unsigned ZR_W  = W + 1;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  localparam logic [ACC_W-1:0] ONES    = '1;
  localparam logic [ACC_W-1:0] LO_MASK = ~(ONES << APPROX_LSBS);
  localparam logic [ZR_W-1:0]  Z_ONE   = ZR_W'(1) << (W - 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] xs_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] term;
  logic signed [ZR_W-1:0]  zr_q;
  logic signed [ZR_W-1:0]  zr_d;
  logic signed [ZR_W-1:0]  step;
  logic [CNT_W-1:0]        cnt_q;
  logic                    mode_q;
  logic                    dir;
  logic                    accept;
  logic                    last;

  // Accumulator adder: low part is bitwise OR when approximate, upper part is exact with no carry-in
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b,
                                               input logic             approx);
    logic [ACC_W-1:0] mask;
    logic [ACC_W-1:0] hi;
    mask = approx ? LO_MASK : '0;
    hi   = (a & ~mask) + (b & ~mask);
    return (hi & ~mask) | ((a | b) & mask);
  endfunction

  // One CORDIC iteration: direction from residual sign, zr == 0 rotates in the add direction
  always_comb begin
    dir     = ~zr_q[ZR_W-1];
    shifted = xs_q >>> cnt_q;
    term    = dir ? shifted : -shifted;
    step    = Z_ONE >> cnt_q;
    acc_d   = acc_add(acc_q, term, mode_q);
    zr_d    = dir ? (zr_q - step) : (zr_q + step);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = (cnt_q == LAST);
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand latch, iteration datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs_q      <= '0;
      acc_q     <= '0;
      zr_q      <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= (state_d == IDLE);
      if (accept) begin
        xs_q   <= {{(ACC_W - W){x[W-1]}}, x} <<< (W - 1);
        zr_q   <= {z[W-1], z};
        acc_q  <= '0;
        cnt_q  <= '0;
        mode_q <= approx_en;
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        zr_q  <= zr_d;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          y         <= acc_d;
          out_valid <= 1'b1;
        end
      end else if (state_q == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cordic_mult_lin_param.sv
// Bench for cordic_mult_lin_param: directed cases plus randomized traffic against a behavioural model.
module tb_cordic_mult_lin_param;

  localparam int unsigned W     = 8;
  localparam int unsigned ITER  = 8;
  localparam int unsigned AL    = 4;
  localparam int unsigned ACC_W = 2 * W + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   z = '0;
  logic           approx_en = 1'b0;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W:0]   y;

  int checks = 0;
  int errors = 0;

  cordic_mult_lin_param #(.W(W), .ITER(ITER), .APPROX_LSBS(AL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .z(z), .approx_en(approx_en),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Wrap an arbitrary integer into a signed ACC_W-bit value
  function automatic longint wrap_acc(input longint v);
    longint m;
    longint r;
    m = longint'(1) << ACC_W;
    r = v & (m - 1);
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic longint add_model(input longint a, input longint b, input bit m);
    longint lo;
    longint hi;
    longint lm;
    if (!m || AL == 0) return wrap_acc(a + b);
    lm = (longint'(1) << AL) - 1;
    lo = (a & lm) | (b & lm);
    hi = (a >>> AL) + (b >>> AL);
    return wrap_acc(hi * (longint'(1) << AL) + lo);
  endfunction

  // Reference product: the linear CORDIC recurrence in plain integer arithmetic
  function automatic longint ref_mult(input int xv, input int zv, input bit m);
    longint acc;
    longint s;
    int     zr;
    int     half;
    acc  = 0;
    zr   = zv;
    half = 1 << (W - 1);
    for (int i = 0; i < int'(ITER); i++) begin
      s = (longint'(xv) * longint'(half)) >>> i;
      if (zr >= 0) begin
        acc = add_model(acc, s, m);
        zr  = zr - (half >> i);
      end else begin
        acc = add_model(acc, -s, m);
        zr  = zr + (half >> i);
      end
    end
    return acc;
  endfunction

  // Transaction-level timing model: 0 idle, 1 busy for ITER edges, 2 holding a result
  int     m_phase = 0;
  int     m_cnt   = 0;
  longint m_res   = 0;
  longint m_y     = 0;
  bit     m_valid = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_y     = 0;
      m_valid = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_res   = ref_mult(int'($signed(x)), int'($signed(z)), approx_en);
          m_cnt   = ITER;
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2;
            m_y     = m_res;
            m_valid = 1'b1;
          end
        end
        default: if (out_ready) begin
          m_phase = 0;
          m_valid = 1'b0;
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_y", longint'($signed(y)), m_y);
      chk("cyc_out_valid", longint'(out_valid), longint'(m_valid));
      chk("cyc_in_ready", longint'(in_ready), longint'(m_phase == 0));
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_in_ready", longint'(in_ready), 1);
  endtask

  // Issue one operation, then check latency and result; leaves the DUT holding the result
  task automatic op(input int xa, input int za, input bit en, input longint exp, input string nm);
    int n;
    wait_ready();
    start     = 1'b1;
    x         = W'(xa);
    z         = W'(za);
    approx_en = en;
    @(negedge clk);
    start     = 1'b0;
    x         = W'($urandom);
    z         = W'($urandom);
    approx_en = 1'($urandom);
    n = 1;
    while (!out_valid && n < int'(ITER) + 6) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, longint'(n), longint'(ITER + 1));
    chk(nm, longint'($signed(y)), exp);
  endtask

  // Hold the result for a while (with stray starts), then hand it off
  task automatic release_out(input int hold, input longint exp);
    for (int i = 0; i < hold; i++) begin
      start = (i < 2);
      x     = W'($urandom);
      z     = W'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("held_y", longint'($signed(y)), exp);
    chk("held_valid", longint'(out_valid), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff_in_ready", longint'(in_ready), 1);
    chk("handoff_out_valid", longint'(out_valid), 0);
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_y", longint'($signed(y)), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Pin the model with hand-computed values
    chk("model_64x64", ref_mult(64, 64, 1'b0), 4160);
    chk("model_corner", ref_mult(-128, -128, 1'b0), 16256);
    chk("model_approx_1x0", ref_mult(1, 0, 1'b1), -33);
    chk("model_exact_1x0", ref_mult(1, 0, 1'b0), 1);
    chk("model_approx_64x64", ref_mult(64, 64, 1'b1), 4160);

    // Directed operations
    op(64, 64, 1'b0, 4160, "exact_pos");
    release_out(10, 4160);
    op(-128, -128, 1'b0, 16256, "exact_corner");
    release_out(2, 16256);
    op(1, 0, 1'b1, -33, "approx_1x0");
    release_out(0, -33);
    op(1, 0, 1'b0, 1, "exact_1x0");

    // Back-to-back: handoff and new start on the same cycle
    out_ready = 1'b1;
    start     = 1'b1;
    x         = W'(64);
    z         = W'(64);
    approx_en = 1'b1;
    @(negedge clk);
    chk("b2b_idle_in_ready", longint'(in_ready), 1);
    chk("b2b_idle_out_valid", longint'(out_valid), 0);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted", longint'(in_ready), 0);
    begin
      int n = 0;
      while (!out_valid && n < int'(ITER) + 6) begin
        @(negedge clk);
        n++;
      end
    end
    chk("b2b_approx_64x64", longint'($signed(y)), 4160);
    release_out(1, 4160);

    // Reset in the middle of an operation
    wait_ready();
    start = 1'b1;
    x     = W'(-77);
    z     = W'(45);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_y", longint'($signed(y)), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    op(64, 64, 1'b0, 4160, "after_rst");
    release_out(0, 4160);

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      x         = W'($urandom);
      z         = W'($urandom);
      approx_en = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
